// File: rtl/affine_pipe_ctrl_gen.sv
// affine_pipe_ctrl_gen
//   Controller for the affine motion-estimation pipeline. It sequences
//   NUM_STAGES pipeline stages over NUM_SUBBLK sub-blocks, one beat every
//   BEAT_CYCLES clocks. It accumulates the per-mode Hadamard cost of each
//   sub-block leaving the last stage, forms the RD cost of every affine mode
//   and picks the cheapest of those and the external ME cost.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a run (level, sampled in IDLE/DONE)
//   load_ram          request a RAM load phase
//   abort             cancel the current run or load
//   rd_cost_me        ME RD cost (candidate 0)
//   lamda_m           Lagrangian multiplier
//   ctrl_point_bits   control-point bits, mode m at [m*BITS_W +: BITS_W]
//   had_cost          Hadamard cost of the sub-block leaving the last stage
//   load_cur_ram      current RAM write enable
//   load_ref_ram      reference RAM write enable
//   en                pipeline run enable
//   stage_en          per-stage data valid, held for a whole beat
//   num_of_sub_blk    sub-blocks issued this run
//   busy              high in LOAD/RUN/DRAIN/DECIDE
//   done              results valid (level)
//   best_mode         0 = ME, m = affine mode m-1
//   rd_cost_min       winning RD cost
module affine_pipe_ctrl_gen #(
  parameter int unsigned BEAT_CYCLES   = 3,
  parameter int unsigned NUM_STAGES    = 7,
  parameter int unsigned NUM_SUBBLK    = 1024,
  parameter int unsigned NUM_AFF_MODES = 2,
  parameter int unsigned HAD_W         = 16,
  parameter int unsigned COST_W        = 21,
  parameter int unsigned LAMBDA_W      = 9,
  parameter int unsigned BITS_W        = 21,
  localparam int unsigned NSB_W        = $clog2(NUM_SUBBLK + 1),
  localparam int unsigned MODE_W       = $clog2(NUM_AFF_MODES + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              load_ram,
  input  logic                              abort,
  input  logic [COST_W-1:0]                 rd_cost_me,
  input  logic [LAMBDA_W-1:0]               lamda_m,
  input  logic [NUM_AFF_MODES*BITS_W-1:0]   ctrl_point_bits,
  input  logic [NUM_AFF_MODES*HAD_W-1:0]    had_cost,
  output logic                              load_cur_ram,
  output logic                              load_ref_ram,
  output logic                              en,
  output logic [NUM_STAGES-1:0]             stage_en,
  output logic [NSB_W-1:0]                  num_of_sub_blk,
  output logic                              busy,
  output logic                              done,
  output logic [MODE_W-1:0]                 best_mode,
  output logic [COST_W-1:0]                 rd_cost_min
);

  localparam int unsigned BC_W   = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned SUM_W  = ((COST_W > HAD_W) ? COST_W : HAD_W) + 1;
  localparam int unsigned PROD_W = LAMBDA_W + BITS_W;
  localparam int unsigned RD_W   = ((COST_W > PROD_W) ? COST_W : PROD_W) + 1;
  localparam logic [COST_W-1:0] COST_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DECIDE,
    S_DONE
  } state_t;

  state_t                 state;
  logic [BC_W-1:0]        beat_cnt;
  logic                   tick;
  logic [NUM_STAGES-1:0]  stage_valid;
  logic [COST_W-1:0]      acc     [NUM_AFF_MODES];
  logic [COST_W-1:0]      acc_sat [NUM_AFF_MODES];
  logic [COST_W-1:0]      rd      [NUM_AFF_MODES];
  logic [MODE_W-1:0]      min_mode;
  logic [COST_W-1:0]      min_cost;

  assign tick     = (beat_cnt == BC_W'(BEAT_CYCLES - 1));
  assign stage_en = stage_valid;

  // Saturating accumulate of the cost leaving the last stage.
  always_comb begin : acc_add
    logic [SUM_W-1:0] sum;
    sum = '0;
    for (int unsigned m = 0; m < NUM_AFF_MODES; m++) begin
      sum = SUM_W'(acc[m]) + SUM_W'(had_cost[m*HAD_W +: HAD_W]);
      acc_sat[m] = (sum > SUM_W'(COST_MAX)) ? COST_MAX : sum[COST_W-1:0];
    end
  end

  // RD cost at full width, clamped to COST_W.
  always_comb begin : rd_calc
    logic [RD_W-1:0] s;
    s = '0;
    for (int unsigned m = 0; m < NUM_AFF_MODES; m++) begin
      s = RD_W'(acc[m]) +
          RD_W'(lamda_m) * RD_W'(ctrl_point_bits[m*BITS_W +: BITS_W]);
      rd[m] = (s > RD_W'(COST_MAX)) ? COST_MAX : s[COST_W-1:0];
    end
  end

  // Strict less-than keeps the earliest candidate on ties, ME first.
  always_comb begin
    min_cost = rd_cost_me;
    min_mode = '0;
    for (int unsigned m = 0; m < NUM_AFF_MODES; m++) begin
      if (rd[m] < min_cost) begin
        min_cost = rd[m];
        min_mode = MODE_W'(m + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      beat_cnt       <= '0;
      stage_valid    <= '0;
      num_of_sub_blk <= '0;
      for (int unsigned m = 0; m < NUM_AFF_MODES; m++) acc[m] <= '0;
      load_cur_ram   <= 1'b0;
      load_ref_ram   <= 1'b0;
      en             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      best_mode      <= '0;
      rd_cost_min    <= '0;
    end else if (abort && state != S_IDLE) begin
      // Results of the previous decision survive an abort.
      state        <= S_IDLE;
      beat_cnt     <= '0;
      stage_valid  <= '0;
      for (int unsigned m = 0; m < NUM_AFF_MODES; m++) acc[m] <= '0;
      load_cur_ram <= 1'b0;
      load_ref_ram <= 1'b0;
      en           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (load_ram) begin
            state        <= S_LOAD;
            load_cur_ram <= 1'b1;
            load_ref_ram <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
          end else if (start) begin
            state          <= S_RUN;
            beat_cnt       <= '0;
            stage_valid    <= '0;
            num_of_sub_blk <= '0;
            for (int unsigned m = 0; m < NUM_AFF_MODES; m++) acc[m] <= '0;
            en             <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
          end
        end

        S_LOAD: begin
          if (!load_ram) begin
            state        <= S_IDLE;
            load_cur_ram <= 1'b0;
            load_ref_ram <= 1'b0;
            busy         <= 1'b0;
          end
        end

        S_RUN: begin
          if (tick) begin
            beat_cnt       <= '0;
            stage_valid    <= (stage_valid << 1) | NUM_STAGES'(1);
            num_of_sub_blk <= num_of_sub_blk + NSB_W'(1);
            if (num_of_sub_blk == NSB_W'(NUM_SUBBLK - 1)) state <= S_DRAIN;
            if (stage_valid[NUM_STAGES-1]) begin
              for (int unsigned m = 0; m < NUM_AFF_MODES; m++) acc[m] <= acc_sat[m];
            end
          end else begin
            beat_cnt <= beat_cnt + BC_W'(1);
          end
        end

        S_DRAIN: begin
          // The empty-pipe test looks at the registered stage_valid, so the
          // decision happens the cycle after the final draining tick.
          if (stage_valid == '0) begin
            state    <= S_DECIDE;
            beat_cnt <= '0;
            en       <= 1'b0;
          end else if (tick) begin
            beat_cnt    <= '0;
            stage_valid <= stage_valid << 1;
            if (stage_valid[NUM_STAGES-1]) begin
              for (int unsigned m = 0; m < NUM_AFF_MODES; m++) acc[m] <= acc_sat[m];
            end
          end else begin
            beat_cnt <= beat_cnt + BC_W'(1);
          end
        end

        S_DECIDE: begin
          best_mode   <= min_mode;
          rd_cost_min <= min_cost;
          state       <= S_DONE;
          done        <= 1'b1;
          busy        <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_affine_pipe_ctrl_gen.sv
module tb_affine_pipe_ctrl_gen;

  localparam int unsigned BEAT   = 3;
  localparam int unsigned STG    = 7;
  localparam int unsigned SUB_A  = 4;
  localparam int unsigned SUB_B  = 64;
  localparam int unsigned MODES  = 2;
  localparam int unsigned HAD_W  = 16;
  localparam int unsigned COST_W = 21;
  localparam int unsigned LAM_W  = 9;
  localparam int unsigned BITS_W = 21;
  localparam int unsigned LAT_A  = BEAT * (SUB_A + STG) + 2;
  localparam int unsigned LAT_B  = BEAT * (SUB_B + STG) + 2;
  localparam logic [COST_W-1:0] CMAX = '1;

  typedef struct {
    logic [1:0]        mode;
    logic [COST_W-1:0] cost;
    int unsigned       cyc;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  logic clk = 1'b0;
  logic rst_n;

  // DUT A: short runs
  logic                      start_a, load_a, abort_a;
  logic [COST_W-1:0]         me_a;
  logic [LAM_W-1:0]          lam_a;
  logic [MODES*BITS_W-1:0]   bits_a;
  logic [MODES*HAD_W-1:0]    had_a;
  logic                      lcur_a, lref_a, en_a, busy_a, done_a;
  logic [STG-1:0]            stg_a;
  logic [2:0]                nsb_a;
  logic [1:0]                mode_a;
  logic [COST_W-1:0]         cost_a;

  // DUT B: long runs for accumulator saturation
  logic                      start_b, load_b, abort_b;
  logic [COST_W-1:0]         me_b;
  logic [LAM_W-1:0]          lam_b;
  logic [MODES*BITS_W-1:0]   bits_b;
  logic [MODES*HAD_W-1:0]    had_b;
  logic                      lcur_b, lref_b, en_b, busy_b, done_b;
  logic [STG-1:0]            stg_b;
  logic [6:0]                nsb_b;
  logic [1:0]                mode_b;
  logic [COST_W-1:0]         cost_b;

  logic [1:0]        last_mode_a;
  logic [COST_W-1:0] last_cost_a;

  affine_pipe_ctrl_gen #(
    .BEAT_CYCLES(BEAT), .NUM_STAGES(STG), .NUM_SUBBLK(SUB_A), .NUM_AFF_MODES(MODES),
    .HAD_W(HAD_W), .COST_W(COST_W), .LAMBDA_W(LAM_W), .BITS_W(BITS_W)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .load_ram(load_a), .abort(abort_a),
    .rd_cost_me(me_a), .lamda_m(lam_a), .ctrl_point_bits(bits_a), .had_cost(had_a),
    .load_cur_ram(lcur_a), .load_ref_ram(lref_a), .en(en_a), .stage_en(stg_a),
    .num_of_sub_blk(nsb_a), .busy(busy_a), .done(done_a), .best_mode(mode_a),
    .rd_cost_min(cost_a)
  );

  affine_pipe_ctrl_gen #(
    .BEAT_CYCLES(BEAT), .NUM_STAGES(STG), .NUM_SUBBLK(SUB_B), .NUM_AFF_MODES(MODES),
    .HAD_W(HAD_W), .COST_W(COST_W), .LAMBDA_W(LAM_W), .BITS_W(BITS_W)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .load_ram(load_b), .abort(abort_b),
    .rd_cost_me(me_b), .lamda_m(lam_b), .ctrl_point_bits(bits_b), .had_cost(had_b),
    .load_cur_ram(lcur_b), .load_ref_ram(lref_b), .en(en_b), .stage_en(stg_b),
    .num_of_sub_blk(nsb_b), .busy(busy_b), .done(done_b), .best_mode(mode_b),
    .rd_cost_min(cost_b)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: every sub-block contributes had[m] once, the running
  // total clips at the cost ceiling; RD = acc + lambda*bits clipped; the
  // first candidate (ME, then mode 0, 1, ...) with the lowest RD wins.
  function automatic void model(input logic [MODES*HAD_W-1:0] had,
                                input logic [LAM_W-1:0] lam,
                                input logic [MODES*BITS_W-1:0] bits,
                                input logic [COST_W-1:0] me,
                                input int unsigned sub,
                                output logic [1:0] mode,
                                output logic [COST_W-1:0] cost);
    longint unsigned best, acc, rd;
    best = 64'(me);
    mode = 2'd0;
    for (int unsigned m = 0; m < MODES; m++) begin
      acc = 64'(had[m*HAD_W +: HAD_W]) * 64'(sub);
      if (acc > 64'(CMAX)) acc = 64'(CMAX);
      rd = acc + 64'(lam) * 64'(bits[m*BITS_W +: BITS_W]);
      if (rd > 64'(CMAX)) rd = 64'(CMAX);
      if (rd < best) begin
        best = rd;
        mode = 2'(m + 1);
      end
    end
    cost = best[COST_W-1:0];
  endfunction

  // Sub-block j enters stage 0 on beat j+1 and reaches stage i on beat j+1+i.
  function automatic logic [STG-1:0] exp_stage(input int unsigned k, input int unsigned sub);
    logic [STG-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < STG; i++)
      for (int unsigned j = 0; j < sub; j++)
        if (j + 1 + i == k) v[i] = 1'b1;
    return v;
  endfunction

  // Scoreboard monitors: compare on each rising edge of done.
  logic done_a_q = 1'b0;
  logic done_b_q = 1'b0;

  always @(negedge clk) begin : mon_a
    exp_t it;
    if (rst_n && done_a && !done_a_q) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_a at cyc=%0d mode=%0d cost=%0d", cyc, mode_a, cost_a);
      end else begin
        it = exp_a.pop_front();
        checks++;
        if (mode_a !== it.mode) begin
          errors++;
          $display("FAIL best_mode_a got=%0d required=%0d", mode_a, it.mode);
        end
        checks++;
        if (cost_a !== it.cost) begin
          errors++;
          $display("FAIL rd_cost_min_a got=%0d required=%0d", cost_a, it.cost);
        end
        checks++;
        if (cyc !== it.cyc) begin
          errors++;
          $display("FAIL latency_a got_cyc=%0d required_cyc=%0d", cyc, it.cyc);
        end
      end
    end
    done_a_q <= rst_n ? done_a : 1'b0;
  end

  always @(negedge clk) begin : mon_b
    exp_t it;
    if (rst_n && done_b && !done_b_q) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done_b at cyc=%0d mode=%0d cost=%0d", cyc, mode_b, cost_b);
      end else begin
        it = exp_b.pop_front();
        checks++;
        if (mode_b !== it.mode) begin
          errors++;
          $display("FAIL best_mode_b got=%0d required=%0d", mode_b, it.mode);
        end
        checks++;
        if (cost_b !== it.cost) begin
          errors++;
          $display("FAIL rd_cost_min_b got=%0d required=%0d", cost_b, it.cost);
        end
        checks++;
        if (cyc !== it.cyc) begin
          errors++;
          $display("FAIL latency_b got_cyc=%0d required_cyc=%0d", cyc, it.cyc);
        end
      end
    end
    done_b_q <= rst_n ? done_b : 1'b0;
  end

  task automatic check_cycle_a(input int unsigned t);
    int unsigned k;
    logic [14:0] expv, gotv;
    k = t / BEAT;
    expv = {(t < BEAT * (SUB_A + STG) + 1), (t < LAT_A), (t >= LAT_A), 1'b0, 1'b0,
            exp_stage(k, SUB_A), 3'((k < SUB_A) ? k : SUB_A)};
    gotv = {en_a, busy_a, done_a, lcur_a, lref_a, stg_a, nsb_a};
    checks++;
    if (gotv !== expv) begin
      errors++;
      $display("FAIL run_ctrl_a t=%0d {en,busy,done,lcur,lref,stage_en,nsb} got=%b required=%b",
               t, gotv, expv);
    end
  endtask

  task automatic check_zero(input string name, input logic [48:0] gotv);
    checks++;
    if (gotv !== '0) begin
      errors++;
      $display("FAIL %s outputs got=%h required=0", name, gotv);
    end
  endtask

  task automatic run_a(input logic [MODES*HAD_W-1:0] had, input logic [LAM_W-1:0] lam,
                       input logic [MODES*BITS_W-1:0] bits, input logic [COST_W-1:0] me);
    int unsigned e0;
    exp_t it;
    had_a = had; lam_a = lam; bits_a = bits; me_a = me;
    start_a = 1'b1;
    @(negedge clk);
    e0 = cyc;
    start_a = 1'b0;
    model(had, lam, bits, me, SUB_A, it.mode, it.cost);
    it.cyc = e0 + LAT_A;
    exp_a.push_back(it);
    for (int unsigned t = 0; t <= LAT_A; t++) begin
      if (t > 0) @(negedge clk);
      check_cycle_a(t);
    end
    last_mode_a = it.mode;
    last_cost_a = it.cost;
  endtask

  task automatic run_b(input logic [MODES*HAD_W-1:0] had, input logic [LAM_W-1:0] lam,
                       input logic [MODES*BITS_W-1:0] bits, input logic [COST_W-1:0] me);
    exp_t it;
    had_b = had; lam_b = lam; bits_b = bits; me_b = me;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    model(had, lam, bits, me, SUB_B, it.mode, it.cost);
    it.cyc = cyc + LAT_B;
    exp_b.push_back(it);
    for (int unsigned i = 0; i < LAT_B + 10 && !done_b; i++) @(negedge clk);
    checks++;
    if (!done_b) begin
      errors++;
      $display("FAIL done_timeout_b got=0 required=1 within %0d cycles", LAT_B + 10);
    end
  endtask

  task automatic rand_vals(output logic [MODES*HAD_W-1:0] had, output logic [LAM_W-1:0] lam,
                           output logic [MODES*BITS_W-1:0] bits, output logic [COST_W-1:0] me,
                           input int unsigned sub);
    logic [1:0] m;
    logic [COST_W-1:0] c;
    for (int unsigned i = 0; i < MODES; i++) begin
      had[i*HAD_W +: HAD_W] = ($urandom_range(0, 3) == 0) ? HAD_W'($urandom)
                                                          : HAD_W'($urandom_range(0, 500));
      bits[i*BITS_W +: BITS_W] = ($urandom_range(0, 4) == 0) ? BITS_W'($urandom)
                                                             : BITS_W'($urandom_range(0, 3000));
    end
    lam = LAM_W'($urandom);
    case ($urandom_range(0, 2))
      0: me = COST_W'($urandom);
      1: me = COST_W'($urandom_range(0, 4000));
      default: begin
        model(had, lam, bits, CMAX, sub, m, c);
        me = c;
      end
    endcase
  endtask

  logic [MODES*HAD_W-1:0]  r_had;
  logic [LAM_W-1:0]        r_lam;
  logic [MODES*BITS_W-1:0] r_bits;
  logic [COST_W-1:0]       r_me;

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; load_a = 1'b0; abort_a = 1'b0;
    me_a = '0; lam_a = '0; bits_a = '0; had_a = '0;
    start_b = 1'b0; load_b = 1'b0; abort_b = 1'b0;
    me_b = '0; lam_b = '0; bits_b = '0; had_b = '0;
    last_mode_a = '0; last_cost_a = '0;

    repeat (3) @(negedge clk);
    check_zero("reset_a", {lcur_a, lref_a, en_a, stg_a, 7'(nsb_a), busy_a, done_a, mode_a, cost_a, 6'd0});
    check_zero("reset_b", {lcur_b, lref_b, en_b, stg_b, nsb_b, busy_b, done_b, mode_b, cost_b, 2'd0});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: affine mode 0 wins, then a tie that goes to ME.
    run_a({16'd20, 16'd10}, 9'd2, {21'd3, 21'd5}, 21'd60);
    run_a({16'd20, 16'd10}, 9'd2, {21'd3, 21'd5}, 21'd50);

    // Abort partway through a run.
    had_a = {16'd7, 16'd9}; lam_a = 9'd1; bits_a = {21'd1, 21'd1}; me_a = 21'd3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checks++;
    if ({en_a, busy_a, done_a, lcur_a, lref_a, stg_a} !== '0) begin
      errors++;
      $display("FAIL abort_ctrl got=%b required=0", {en_a, busy_a, done_a, lcur_a, lref_a, stg_a});
    end
    checks++;
    if ({mode_a, cost_a} !== {last_mode_a, last_cost_a}) begin
      errors++;
      $display("FAIL abort_hold got mode=%0d cost=%0d required mode=%0d cost=%0d",
               mode_a, cost_a, last_mode_a, last_cost_a);
    end
    @(negedge clk);
    checks++;
    if ({en_a, busy_a, done_a} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle got=%b required=000", {en_a, busy_a, done_a});
    end
    run_a({16'd20, 16'd10}, 9'd2, {21'd3, 21'd5}, 21'd60);

    // load_ram beats start; dropping it returns to IDLE.
    load_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    checks++;
    if ({lcur_a, lref_a, busy_a, en_a, done_a} !== 5'b11100) begin
      errors++;
      $display("FAIL load_enter got=%b required=11100", {lcur_a, lref_a, busy_a, en_a, done_a});
    end
    @(negedge clk);
    checks++;
    if ({lcur_a, lref_a, busy_a, en_a, done_a} !== 5'b11100) begin
      errors++;
      $display("FAIL load_hold got=%b required=11100", {lcur_a, lref_a, busy_a, en_a, done_a});
    end
    load_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({lcur_a, lref_a, busy_a, en_a, done_a} !== 5'b00000) begin
      errors++;
      $display("FAIL load_exit got=%b required=00000", {lcur_a, lref_a, busy_a, en_a, done_a});
    end
    run_a({16'd20, 16'd10}, 9'd2, {21'd3, 21'd5}, 21'd60);

    // Randomised runs.
    repeat (8) begin
      rand_vals(r_had, r_lam, r_bits, r_me, SUB_A);
      run_a(r_had, r_lam, r_bits, r_me);
    end

    // Reset in the middle of DRAIN.
    had_a = {16'd5, 16'd6}; lam_a = 9'd3; bits_a = {21'd2, 21'd2}; me_a = 21'd100;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (BEAT * SUB_A + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("reset_mid_drain", {lcur_a, lref_a, en_a, stg_a, 7'(nsb_a), busy_a, done_a, mode_a, cost_a, 6'd0});
    rst_n = 1'b1;
    last_mode_a = '0; last_cost_a = '0;
    @(negedge clk);
    rand_vals(r_had, r_lam, r_bits, r_me, SUB_A);
    run_a(r_had, r_lam, r_bits, r_me);

    // Long runs: both accumulators clip at the ceiling.
    run_b({16'hFFFF, 16'hFFFF}, 9'd0, {21'd17, 21'd4}, CMAX);
    run_b({16'hFFFF, 16'hFFFF}, 9'd0, {21'd17, 21'd4}, CMAX - 21'd1);
    repeat (2) begin
      rand_vals(r_had, r_lam, r_bits, r_me, SUB_B);
      run_b(r_had, r_lam, r_bits, r_me);
    end

    @(negedge clk);
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending_a=%0d pending_b=%0d required=0", exp_a.size(), exp_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d required=finish before limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule
